// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and a debug port.
// Round-robin on ties, with a bounded debug lock and single-beat access.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          lock_timeout
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam int            CW       = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    state_t        state;
    state_t        state_nx;
    logic          last_dbg;
    logic          last_dbg_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          armed;
    logic          armed_nx;
    logic          tmo_nx;

    always_comb begin
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        state_nx    = state;
        last_dbg_nx = last_dbg;
        cnt_nx      = cnt;
        armed_nx    = armed;
        tmo_nx      = 1'b0;
        if (rst) begin
            unique case (state)
                UNLOCKED: begin
                    if (cpu_req && dbg_req) begin
                        cpu_gnt = last_dbg;
                        dbg_gnt = ~last_dbg;
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                    if (dbg_gnt && dbg_lock && armed) begin
                        state_nx = LOCKED;
                        cnt_nx   = '0;
                    end
                end
                LOCKED: begin
                    dbg_gnt = dbg_req;
                    if (!dbg_lock) begin
                        state_nx = UNLOCKED;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        // forced release: debug must re-request the lock
                        state_nx = UNLOCKED;
                        cnt_nx   = '0;
                        tmo_nx   = 1'b1;
                        armed_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            endcase
            if (!dbg_lock) armed_nx = 1'b1;
            if (cpu_gnt) last_dbg_nx = 1'b0;
            else if (dbg_gnt) last_dbg_nx = 1'b1;
            if (tmo_nx) last_dbg_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= UNLOCKED;
            last_dbg     <= 1'b1;
            cnt          <= '0;
            armed        <= 1'b1;
            lock_timeout <= 1'b0;
            cpu_rvalid   <= 1'b0;
            dbg_rvalid   <= 1'b0;
        end else begin
            state        <= state_nx;
            last_dbg     <= last_dbg_nx;
            cnt          <= cnt_nx;
            armed        <= armed_nx;
            lock_timeout <= tmo_nx;
            cpu_rvalid   <= cpu_gnt & ~cpu_we;
            dbg_rvalid   <= dbg_gnt & ~dbg_we;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_en    = cpu_gnt | dbg_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign rdata = (cpu_rvalid | dbg_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          lock_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lock_timeout(lock_timeout)
    );

    // behavioural model: lock tracked as remaining locked cycles
    bit m_locked, m_last_dbg, m_armed, m_tmo;
    int m_left;
    int m_rv;
    bit e_cpu, e_dbg;

    function automatic void model_reset();
        m_locked   = 0;
        m_last_dbg = 1;
        m_armed    = 1;
        m_tmo      = 0;
        m_left     = 0;
        m_rv       = 0;
    endfunction

    function automatic void model_grant();
        e_cpu = 0;
        e_dbg = 0;
        if (rst) begin
            if (m_locked) e_dbg = dbg_req;
            else if (cpu_req && dbg_req) begin
                e_cpu = m_last_dbg;
                e_dbg = !m_last_dbg;
            end else begin
                e_cpu = cpu_req;
                e_dbg = dbg_req;
            end
        end
    endfunction

    function automatic logic [55:0] model_out();
        logic        we;
        logic [15:0] a, w, r;
        model_grant();
        we = e_cpu ? cpu_we : (e_dbg ? dbg_we : 1'b0);
        a  = e_cpu ? cpu_addr : (e_dbg ? dbg_addr : 16'h0);
        w  = e_cpu ? cpu_wdata : (e_dbg ? dbg_wdata : 16'h0);
        r  = (m_rv != 0) ? mem_rdata : 16'h0;
        return {e_cpu, e_dbg, cpu_req & ~e_cpu, m_rv == 1, m_rv == 2,
                e_cpu | e_dbg, we, m_tmo, a, w, r};
    endfunction

    function automatic void model_update();
        int rv;
        if (!rst) begin
            model_reset();
            return;
        end
        model_grant();
        rv = (e_cpu && !cpu_we) ? 1 : ((e_dbg && !dbg_we) ? 2 : 0);
        m_tmo = 0;
        if (e_cpu) m_last_dbg = 0;
        if (e_dbg) m_last_dbg = 1;
        if (m_locked) begin
            if (!dbg_lock) m_locked = 0;
            else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_locked   = 0;
                    m_tmo      = 1;
                    m_armed    = 0;
                    m_last_dbg = 1;
                end
            end
        end else if (e_dbg && dbg_lock && m_armed) begin
            m_locked = 1;
            m_left   = LM;
        end
        if (!dbg_lock) m_armed = 1;
        m_rv = rv;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0;
        dbg_addr = '0; dbg_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        cpu_req = 1; dbg_req = 1;
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, lock_timeout}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, lock_timeout});
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_hi: got %b want 1", cpu_stall);
        end
        cpu_req = 0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_lo: got %b want 0", cpu_stall);
        end
        dbg_req = 0;
        @(posedge clk);
        #1;
        rst = 1;
        cpu_req = 1; dbg_req = 1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL first_grant: got %b want 10", {cpu_gnt, dbg_gnt});
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 16'h0010}) begin
            errors++;
            $display("FAIL cpu_read_grant: got %b %b %b %h want 1 1 0 0010",
                     cpu_gnt, mem_en, mem_we, mem_addr);
        end
        tick();
        idle();
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rdata} !== {2'b10, 16'hBEEF}) begin
            errors++;
            $display("FAIL cpu_read_data: got %b %b %h want 1 0 beef",
                     cpu_rvalid, dbg_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                cpu_req = 0; dbg_req = 0;
            end
            mem_rdata = 16'hA000 + 16'(i);
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if ({cpu_gnt, dbg_gnt, cpu_stall} !==
                    ((i % 2 == 0) ? 3'b100 : 3'b011)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b", i,
                             {cpu_gnt, dbg_gnt, cpu_stall});
                end
            end
            if (i > 0) begin
                checks++;
                if ({cpu_rvalid, dbg_rvalid, rdata} !==
                    {((i % 2 == 1) ? 2'b10 : 2'b01), 16'hA000 + 16'(i)}) begin
                    errors++;
                    $display("FAIL rr_rvalid[%0d]: got %b %b %h", i,
                             cpu_rvalid, dbg_rvalid, rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_lock_release();
        do_reset();
        dbg_req = 1; dbg_lock = 1;
        tick();
        cpu_req = 1;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) dbg_lock = 0;
            @(negedge clk);
            checks++;
            if ({cpu_gnt, cpu_stall, dbg_gnt} !== 3'b011) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got %b want 011", i,
                         {cpu_gnt, cpu_stall, dbg_gnt});
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dbg_gnt, lock_timeout} !== 3'b100) begin
            errors++;
            $display("FAIL lock_release: got %b want 100",
                     {cpu_gnt, dbg_gnt, lock_timeout});
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_lock_timeout();
        logic [2:0] want [12];
        want = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b101,
                 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b010};
        do_reset();
        dbg_req = 1; dbg_lock = 1;
        for (int i = 0; i < 12; i++) begin
            cpu_req  = (i != 0);
            dbg_lock = (i != 8);
            @(negedge clk);
            checks++;
            if ({cpu_gnt, dbg_gnt, lock_timeout} !== want[i]) begin
                errors++;
                $display("FAIL lock_timeout[%0d]: got %b want %b", i,
                         {cpu_gnt, dbg_gnt, lock_timeout}, want[i]);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_dbg_write();
        do_reset();
        dbg_req = 1; dbg_we = 1;
        dbg_addr = 16'h0020; dbg_wdata = 16'h1234;
        @(negedge clk);
        checks++;
        if ({dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
            {3'b111, 16'h0020, 16'h1234}) begin
            errors++;
            $display("FAIL dbg_write: got %b %b %b %h %h", dbg_gnt, mem_en,
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        idle();
        mem_rdata = 16'h5555;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rdata} !== 18'h0) begin
            errors++;
            $display("FAIL dbg_write_norv: got %b %b %h", cpu_rvalid,
                     dbg_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        dbg_req = 1; dbg_lock = 1;
        tick();
        cpu_req = 1;
        tick();
        rst = 0;
        model_reset();
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en,
             lock_timeout, cpu_stall} !== 7'b0000001) begin
            errors++;
            $display("FAIL midreset_lock: got %b want 0000001",
                     {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en,
                      lock_timeout, cpu_stall});
        end
        @(posedge clk);
        #1;
        rst = 1;
        dbg_lock = 0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_unlocked: got %b want 10",
                     {cpu_gnt, dbg_gnt});
        end
        tick();
        idle();
        cpu_req = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        tick();
        cpu_req = 0;
        mem_rdata = 16'h7777;
        #1;
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rdata} !== 18'h0) begin
            errors++;
            $display("FAIL midreset_norv_low: got %b %b %h", cpu_rvalid,
                     dbg_rvalid, rdata);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, dbg_rvalid, rdata} !== 18'h0) begin
            errors++;
            $display("FAIL midreset_norv_after: got %b %b %h", cpu_rvalid,
                     dbg_rvalid, rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [55:0] exp;
        logic [55:0] act;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 16'($urandom);
            cpu_wdata = 16'($urandom);
            dbg_req   = ($urandom_range(0, 9) < 5);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = 16'($urandom);
            dbg_wdata = 16'($urandom);
            mem_rdata = 16'($urandom);
            if ($urandom_range(0, 9) == 0) dbg_lock = ~dbg_lock;
            if (!rst) rst = 1;
            else if ($urandom_range(0, 149) == 0) begin
                rst = 0;
                model_reset();
            end
            @(negedge clk);
            exp = model_out();
            act = {cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid,
                   mem_en, mem_we, lock_timeout, mem_addr, mem_wdata, rdata};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, act, exp);
            end
            tick();
        end
        rst = 1;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_lock_release();
        test_lock_timeout();
        test_dbg_write();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
